// File: rtl/bu_addsub_64.sv
// Butterfly add/sub back end for the 64-bit BU.
// Delays A to meet WB, then forms A+WB and A-WB mod q, optionally halved.
module bu_addsub_64 #(
   parameter int DELAY = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] q,
   input  logic        in_valid,
   input  logic [1:0]  mode,
   input  logic [63:0] a_in,
   input  logic [63:0] wb_in,
   output logic [63:0] e_out,
   output logic [63:0] o_out,
   output logic        out_valid
);

   logic [DELAY-1:0]        dl_valid;
   logic [DELAY-1:0][1:0]   dl_mode;
   logic [DELAY-1:0][63:0]  dl_a;

   logic        s1_valid;
   logic [1:0]  s1_mode;
   logic [63:0] s1_a;
   logic [63:0] s1_wb;
   logic [64:0] s1_sum;
   logic [64:0] s1_diff;

   logic [63:0] s_red;
   logic [63:0] d_red;
   logic [63:0] e_next;
   logic [63:0] o_next;

   // (x + q) / 2 for odd x written as x/2 + q/2 + 1 so it stays in 64 bits
   function automatic logic [63:0] halve(
      input logic [63:0] x,
      input logic [62:0] qh
   );
      logic [63:0] r;
      r = {1'b0, x[63:1]};
      if (x[0]) begin
         r = r + {1'b0, qh} + 64'd1;
      end
      return r;
   endfunction

   // Delay line: A, mode and valid travel alongside the multiplier latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_valid <= '0;
         dl_mode  <= '0;
         dl_a     <= '0;
      end else begin
         dl_valid[0] <= in_valid;
         dl_mode[0]  <= mode;
         dl_a[0]     <= a_in;
         for (int i = 1; i < DELAY; i++) begin
            dl_valid[i] <= dl_valid[i-1];
            dl_mode[i]  <= dl_mode[i-1];
            dl_a[i]     <= dl_a[i-1];
         end
      end
   end

   // Stage 1: raw 65-bit sum and difference plus operand copies
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_mode  <= 2'd0;
         s1_a     <= 64'd0;
         s1_wb    <= 64'd0;
         s1_sum   <= 65'd0;
         s1_diff  <= 65'd0;
      end else begin
         s1_valid <= dl_valid[DELAY-1];
         s1_mode  <= dl_mode[DELAY-1];
         s1_a     <= dl_a[DELAY-1];
         s1_wb    <= wb_in;
         s1_sum   <= {1'b0, dl_a[DELAY-1]} + {1'b0, wb_in};
         s1_diff  <= {1'b0, dl_a[DELAY-1]} - {1'b0, wb_in};
      end
   end

   // Stage 2 combinational: modular correction, optional halving, mode select
   always_comb begin
      s_red = s1_sum[63:0];
      if (s1_sum >= {1'b0, q}) begin
         s_red = s1_sum[63:0] - q;
      end
      d_red = s1_diff[63:0];
      if (s1_diff[64]) begin
         d_red = s1_diff[63:0] + q;
      end
      e_next = s_red;
      o_next = d_red;
      if (s1_mode[1]) begin
         e_next = s1_a;
         o_next = s1_wb;
      end else if (s1_mode[0]) begin
         e_next = halve(s_red, q[63:1]);
         o_next = halve(d_red, q[63:1]);
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_out     <= 64'd0;
         o_out     <= 64'd0;
         out_valid <= 1'b0;
      end else begin
         e_out     <= e_next;
         o_out     <= o_next;
         out_valid <= s1_valid;
      end
   end

endmodule

// File: tb/tb_bu_addsub_64.sv
// Self-checking bench for bu_addsub_64 at DELAY = 8 and DELAY = 1.
// Both instances share A/mode/valid; each gets WB at its own latency.
module tb_bu_addsub_64;

   localparam logic [63:0]  Q    = 64'hFFFFFFFF00000001;
   localparam logic [127:0] Q128 = {64'd0, Q};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [63:0] a_in = 64'd0;
   logic [63:0] wb8 = 64'd0;
   logic [63:0] wb1 = 64'd0;
   logic [63:0] e8, o8, e1, o1;
   logic        v8, v1;

   int n_pass = 0;
   int n_total = 0;

   bit          st_v  [64];
   logic [1:0]  st_m  [64];
   logic [63:0] st_a  [64];
   logic [63:0] st_wb [64];

   logic        ov8 [80];
   logic        ov1 [80];
   logic [63:0] oe8 [80];
   logic [63:0] oo8 [80];
   logic [63:0] oe1 [80];
   logic [63:0] oo1 [80];

   always #5 clk = ~clk;

   bu_addsub_64 #(.DELAY(8)) dut8 (
      .clk(clk), .rst(rst), .q(Q), .in_valid(in_valid), .mode(mode),
      .a_in(a_in), .wb_in(wb8), .e_out(e8), .o_out(o8), .out_valid(v8)
   );

   bu_addsub_64 #(.DELAY(1)) dut1 (
      .clk(clk), .rst(rst), .q(Q), .in_valid(in_valid), .mode(mode),
      .a_in(a_in), .wb_in(wb1), .e_out(e1), .o_out(o1), .out_valid(v1)
   );

   // Reference: modular arithmetic in 128 bits, halving as multiply by 2^-1 mod q
   function automatic logic [127:0] model(
      input logic [1:0] m, input logic [63:0] a, input logic [63:0] wb
   );
      logic [127:0] s, d, inv2;
      if (m[1]) return {a, wb};
      s = ({64'd0, a} + {64'd0, wb}) % Q128;
      d = ({64'd0, a} + Q128 - {64'd0, wb}) % Q128;
      if (m[0]) begin
         inv2 = (Q128 + 128'd1) / 128'd2;
         s = (s * inv2) % Q128;
         d = (d * inv2) % Q128;
      end
      return {s[63:0], d[63:0]};
   endfunction

   function automatic logic [63:0] rnd_op();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: return Q - 64'd1;
         1: return 64'd0;
         default: return r % Q;
      endcase
   endfunction

   // Drive st_* ops from edge 0, feed WB at each instance's latency, record outputs per edge
   task automatic run_ops(input int n);
      for (int t = 0; t < n + 11; t++) begin
         @(negedge clk);
         in_valid = (t < n) ? st_v[t] : 1'b0;
         mode     = (t < n) ? st_m[t] : 2'($urandom);
         a_in     = (t < n) ? st_a[t] : {$urandom, $urandom};
         wb8 = {$urandom, $urandom};
         if (t >= 8 && t - 8 < n) wb8 = st_wb[t-8];
         wb1 = {$urandom, $urandom};
         if (t >= 1 && t - 1 < n) wb1 = st_wb[t-1];
         @(posedge clk);
         #1;
         ov8[t] = v8; oe8[t] = e8; oo8[t] = o8;
         ov1[t] = v1; oe1[t] = e1; oo1[t] = o1;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (v8 !== 1'b0) $display("FAIL reset_v8 got %b want 0", v8); else n_pass++;
      n_total++; if (e8 !== 64'd0) $display("FAIL reset_e8 got %h want 0", e8); else n_pass++;
      n_total++; if (o8 !== 64'd0) $display("FAIL reset_o8 got %h want 0", o8); else n_pass++;
      n_total++; if (v1 !== 1'b0) $display("FAIL reset_v1 got %b want 0", v1); else n_pass++;
      n_total++; if (e1 !== 64'd0) $display("FAIL reset_e1 got %h want 0", e1); else n_pass++;
      n_total++; if (o1 !== 64'd0) $display("FAIL reset_o1 got %h want 0", o1); else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      st_v[0] = 1'b1; st_m[0] = 2'b00; st_a[0] = 64'd5; st_wb[0] = 64'd3;
      run_ops(1);
      for (int t = 0; t < 12; t++) begin
         n_total++;
         if (ov8[t] !== (t == 9)) $display("FAIL basic_v8[%0d] got %b want %b", t, ov8[t], t == 9);
         else n_pass++;
      end
      n_total++; if (oe8[9] !== 64'd8) $display("FAIL basic_e8 got %h want 8", oe8[9]); else n_pass++;
      n_total++; if (oo8[9] !== 64'd2) $display("FAIL basic_o8 got %h want 2", oo8[9]); else n_pass++;
      n_total++; if (ov1[2] !== 1'b1) $display("FAIL basic_v1 got %b want 1", ov1[2]); else n_pass++;
      n_total++; if (oe1[2] !== 64'd8) $display("FAIL basic_e1 got %h want 8", oe1[2]); else n_pass++;
      n_total++; if (oo1[2] !== 64'd2) $display("FAIL basic_o1 got %h want 2", oo1[2]); else n_pass++;
   endtask

   task automatic test_wraps;
      logic [63:0] we [3];
      logic [63:0] wo [3];
      st_v[0] = 1'b1; st_m[0] = 2'b00; st_a[0] = Q - 64'd1; st_wb[0] = Q - 64'd1;
      st_v[1] = 1'b1; st_m[1] = 2'b00; st_a[1] = 64'd0;     st_wb[1] = 64'd1;
      st_v[2] = 1'b1; st_m[2] = 2'b00; st_a[2] = 64'd1;     st_wb[2] = Q - 64'd1;
      we[0] = 64'hFFFFFFFEFFFFFFFF; wo[0] = 64'd0;
      we[1] = 64'd1;                wo[1] = 64'hFFFFFFFF00000000;
      we[2] = 64'd0;                wo[2] = 64'd2;
      run_ops(3);
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (oe8[j+9] !== we[j]) $display("FAIL wrap_e[%0d] got %h want %h", j, oe8[j+9], we[j]);
         else n_pass++;
         n_total++;
         if (oo8[j+9] !== wo[j]) $display("FAIL wrap_o[%0d] got %h want %h", j, oo8[j+9], wo[j]);
         else n_pass++;
      end
   endtask

   task automatic test_halving;
      logic [63:0] we [3];
      logic [63:0] wo [3];
      st_v[0] = 1'b1; st_m[0] = 2'b01; st_a[0] = 64'd1;     st_wb[0] = 64'd0;
      st_v[1] = 1'b1; st_m[1] = 2'b01; st_a[1] = 64'd4;     st_wb[1] = 64'd2;
      st_v[2] = 1'b1; st_m[2] = 2'b01; st_a[2] = Q - 64'd1; st_wb[2] = 64'd0;
      we[0] = 64'h7FFFFFFF80000001; wo[0] = 64'h7FFFFFFF80000001;
      we[1] = 64'd3;                wo[1] = 64'd1;
      we[2] = 64'h7FFFFFFF80000000; wo[2] = 64'h7FFFFFFF80000000;
      run_ops(3);
      for (int j = 0; j < 3; j++) begin
         n_total++;
         if (oe8[j+9] !== we[j]) $display("FAIL half_e[%0d] got %h want %h", j, oe8[j+9], we[j]);
         else n_pass++;
         n_total++;
         if (oo8[j+9] !== wo[j]) $display("FAIL half_o[%0d] got %h want %h", j, oo8[j+9], wo[j]);
         else n_pass++;
      end
   endtask

   task automatic test_passthru;
      st_v[0] = 1'b1; st_m[0] = 2'b10; st_a[0] = 64'h1234; st_wb[0] = 64'hABCD;
      st_v[1] = 1'b1; st_m[1] = 2'b11; st_a[1] = 64'h55;   st_wb[1] = 64'h77;
      run_ops(2);
      n_total++; if (oe8[9] !== 64'h1234) $display("FAIL pass_e got %h want 1234", oe8[9]); else n_pass++;
      n_total++; if (oo8[9] !== 64'hABCD) $display("FAIL pass_o got %h want abcd", oo8[9]); else n_pass++;
      n_total++; if (oe8[10] !== 64'h55) $display("FAIL pass11_e got %h want 55", oe8[10]); else n_pass++;
      n_total++; if (oo8[10] !== 64'h77) $display("FAIL pass11_o got %h want 77", oo8[10]); else n_pass++;
   endtask

   task automatic test_back_to_back;
      int b0, b1, b2, j8, j1;
      logic [127:0] r;
      b0 = 5;
      b1 = 6 + int'($urandom_range(0, 9));
      b2 = 20 + int'($urandom_range(0, 9));
      for (int i = 0; i < 35; i++) begin
         st_v[i]  = !(i == b0 || i == b1 || i == b2);
         st_m[i]  = 2'($urandom);
         st_a[i]  = rnd_op();
         st_wb[i] = rnd_op();
      end
      run_ops(35);
      for (int t = 0; t < 46; t++) begin
         j8 = t - 9;
         j1 = t - 2;
         n_total++;
         if (ov8[t] !== (j8 >= 0 && j8 < 35 && st_v[j8]))
            $display("FAIL stream_v8[%0d] got %b", t, ov8[t]);
         else n_pass++;
         n_total++;
         if (ov1[t] !== (j1 >= 0 && j1 < 35 && st_v[j1]))
            $display("FAIL stream_v1[%0d] got %b", t, ov1[t]);
         else n_pass++;
         if (j8 >= 0 && j8 < 35 && st_v[j8]) begin
            r = model(st_m[j8], st_a[j8], st_wb[j8]);
            n_total++;
            if ({oe8[t], oo8[t]} !== r)
               $display("FAIL stream8 op%0d got %h/%h want %h/%h", j8, oe8[t], oo8[t], r[127:64], r[63:0]);
            else n_pass++;
         end
         if (j1 >= 0 && j1 < 35 && st_v[j1]) begin
            r = model(st_m[j1], st_a[j1], st_wb[j1]);
            n_total++;
            if ({oe1[t], oo1[t]} !== r)
               $display("FAIL stream1 op%0d got %h/%h want %h/%h", j1, oe1[t], oo1[t], r[127:64], r[63:0]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_mid_reset;
      int f8, f1;
      logic [63:0] ce8, co8, ce1, co1;
      for (int t = 0; t < 11; t++) begin
         @(negedge clk);
         in_valid = (t < 5);
         mode = 2'b00;
         a_in = 64'd100 + 64'(t);
         wb8 = (t >= 8) ? 64'd10 + 64'(t - 8) : {$urandom, $urandom} % Q;
         wb1 = (t >= 1 && t < 6) ? 64'd10 + 64'(t - 1) : {$urandom, $urandom} % Q;
         @(posedge clk);
      end
      #3;
      n_total++; if (v8 !== 1'b1) $display("FAIL rst_pre_v8 got %b want 1", v8); else n_pass++;
      rst = 1'b1;
      #1;
      n_total++; if (v8 !== 1'b0) $display("FAIL rst_v8 got %b want 0", v8); else n_pass++;
      n_total++; if (e8 !== 64'd0) $display("FAIL rst_e8 got %h want 0", e8); else n_pass++;
      n_total++; if (o8 !== 64'd0) $display("FAIL rst_o8 got %h want 0", o8); else n_pass++;
      n_total++; if (v1 !== 1'b0) $display("FAIL rst_v1 got %b want 0", v1); else n_pass++;
      n_total++; if (e1 !== 64'd0) $display("FAIL rst_e1 got %h want 0", e1); else n_pass++;
      n_total++; if (o1 !== 64'd0) $display("FAIL rst_o1 got %h want 0", o1); else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(posedge clk);
         #1;
         n_total++;
         if ({v8, v1} !== 2'b00) $display("FAIL quiet[%0d] got v8=%b v1=%b want 0", t, v8, v1);
         else n_pass++;
      end
      f8 = -1; f1 = -1;
      ce8 = '0; co8 = '0; ce1 = '0; co1 = '0;
      for (int t = 0; t < 14; t++) begin
         @(negedge clk);
         in_valid = (t == 0);
         mode = 2'b00;
         a_in = 64'd7;
         wb8 = (t == 8) ? 64'd2 : {$urandom, $urandom} % Q;
         wb1 = (t == 1) ? 64'd2 : {$urandom, $urandom} % Q;
         @(posedge clk);
         #1;
         if (v8 && f8 < 0) begin f8 = t; ce8 = e8; co8 = o8; end
         if (v1 && f1 < 0) begin f1 = t; ce1 = e1; co1 = o1; end
      end
      n_total++; if (f8 != 9) $display("FAIL post_lat8 got %0d want 9", f8); else n_pass++;
      n_total++; if (f1 != 2) $display("FAIL post_lat1 got %0d want 2", f1); else n_pass++;
      n_total++; if ({ce8, co8} !== {64'd9, 64'd5}) $display("FAIL post_eo8 got %h/%h want 9/5", ce8, co8); else n_pass++;
      n_total++; if ({ce1, co1} !== {64'd9, 64'd5}) $display("FAIL post_eo1 got %h/%h want 9/5", ce1, co1); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wraps();
      test_halving();
      test_passthru();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
